// File: rtl/branch_predictor.sv
// Branch target buffer with a 2-bit bimodal direction predictor.
// Fetch-side prediction is purely combinational on pc_i. Resolved-branch
// reports are registered into stage U1, then read-modify-written into the
// arrays on the following edge.
// Optional feature: define BPU_BYPASS_EN to forward the U1 write to a fetch
// lookup of the same index and tag in the write cycle.
module branch_predictor #(
    parameter int unsigned ENTRY_NUM = 64,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned AWDTH     = $clog2(ENTRY_NUM)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            hit_o,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int unsigned TW = XLEN - AWDTH - 2;

    // Entry valid bits are the only reset state of the arrays.
    logic [ENTRY_NUM-1:0] valid_q;

    // Distributed-RAM style arrays, asynchronous read, not reset.
    logic [TW-1:0]   tag_ram   [ENTRY_NUM];
    logic [XLEN-1:0] tgt_ram   [ENTRY_NUM];
    logic [1:0]      ctr_f_ram [ENTRY_NUM];  // fetch-port copy
    logic [1:0]      ctr_u_ram [ENTRY_NUM];  // update-port copy

    // Stage U1 registers.
    logic             u1_valid_q;
    logic [AWDTH-1:0] u1_idx_q;
    logic [TW-1:0]    u1_tag_q;
    logic             u1_taken_q;
    logic [XLEN-1:0]  u1_target_q;

    // PC byte-offset bits play no part in indexing or tagging.
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {pc_i[1:0], upd_pc_i[1:0]};

    logic             u_hit;
    logic [1:0]       u_rd_ctr;
    logic [1:0]       wr_ctr;
    logic             ctr_we;
    logic             tgt_we;
    logic             alloc;

    logic [AWDTH-1:0] f_idx;
    logic [TW-1:0]    f_tag;
    logic             f_hit;
    logic [1:0]       f_ctr;
    logic [XLEN-1:0]  f_tgt;

    // Capture resolved-branch reports into U1; reset drops any in-flight write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            u1_valid_q  <= 1'b0;
            u1_idx_q    <= '0;
            u1_tag_q    <= '0;
            u1_taken_q  <= 1'b0;
            u1_target_q <= '0;
        end else begin
            u1_valid_q <= upd_valid_i;
            if (upd_valid_i) begin
                u1_idx_q    <= upd_pc_i[AWDTH+1:2];
                u1_tag_q    <= upd_pc_i[XLEN-1:AWDTH+2];
                u1_taken_q  <= upd_taken_i;
                u1_target_q <= upd_target_i;
            end
        end
    end

    // Read the U1 entry and decide what gets written at the next edge.
    always_comb begin
        u_rd_ctr = ctr_u_ram[u1_idx_q];
        u_hit    = valid_q[u1_idx_q] && (tag_ram[u1_idx_q] == u1_tag_q);
        wr_ctr   = u_rd_ctr;
        ctr_we   = 1'b0;
        tgt_we   = 1'b0;
        alloc    = 1'b0;
        if (u1_valid_q) begin
            if (u_hit) begin
                ctr_we = 1'b1;
                if (u1_taken_q) begin
                    tgt_we = 1'b1;
                    wr_ctr = (u_rd_ctr == 2'b11) ? 2'b11 : u_rd_ctr + 2'd1;
                end else begin
                    wr_ctr = (u_rd_ctr == 2'b00) ? 2'b00 : u_rd_ctr - 2'd1;
                end
            end else if (u1_taken_q) begin
                // Allocation replaces whatever entry occupied this index.
                alloc  = 1'b1;
                ctr_we = 1'b1;
                tgt_we = 1'b1;
                wr_ctr = 2'b10;
            end
        end
    end

    // Valid bits: set on allocation, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[u1_idx_q] <= 1'b1;
        end
    end

    // RAM writes; both counter copies are kept identical.
    always_ff @(posedge clk_i) begin
        if (ctr_we) begin
            ctr_f_ram[u1_idx_q] <= wr_ctr;
            ctr_u_ram[u1_idx_q] <= wr_ctr;
        end
        if (tgt_we) begin
            tgt_ram[u1_idx_q] <= u1_target_q;
        end
        if (alloc) begin
            tag_ram[u1_idx_q] <= u1_tag_q;
        end
    end

    // Fetch-side lookup, optionally forwarding the write in progress.
    always_comb begin
        f_idx = pc_i[AWDTH+1:2];
        f_tag = pc_i[XLEN-1:AWDTH+2];
        f_hit = valid_q[f_idx] && (tag_ram[f_idx] == f_tag);
        f_ctr = ctr_f_ram[f_idx];
        f_tgt = tgt_ram[f_idx];
`ifdef BPU_BYPASS_EN
        // ctr_we covers every writing case, so a miss/not-taken is never forwarded.
        if (ctr_we && (f_idx == u1_idx_q) && (f_tag == u1_tag_q)) begin
            f_hit = 1'b1;
            f_ctr = wr_ctr;
            if (tgt_we) begin
                f_tgt = u1_target_q;
            end
        end
`endif
        hit_o    = f_hit;
        taken_o  = f_hit & f_ctr[1];
        target_o = f_hit ? f_tgt : '0;
    end

endmodule
